// File: rtl/execute_x_pipe.sv
// Parametrised integer X pipe: ALU/shifter evaluation in X0, then DEPTH pipeline
// registers to writeback, with global hold/flush, overflow flag and bypass lookup.

module execute_x_pipe_x0 #(
  parameter int DATA_W = 32
) (
  input  logic              selalushift,
  input  logic              selimregb,
  input  logic [2:0]        aluop,
  input  logic              unsig,
  input  logic [1:0]        shiftop,
  input  logic [4:0]        shiftamt,
  input  logic [DATA_W-1:0] rega,
  input  logic [DATA_W-1:0] regb,
  input  logic [DATA_W-1:0] imedext,
  output logic [DATA_W-1:0] result,
  output logic              aluov
);
  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  logic [DATA_W-1:0] op_b, sum, diff, alu_res, sh_res;
  logic [SH_W-1:0]   shamt;
  logic              lt;

  // Only the low log2(DATA_W) bits of the amount are meaningful.
  if (SH_W <= 5) begin : g_sh_narrow
    assign shamt = shiftamt[SH_W-1:0];
  end else begin : g_sh_wide
    assign shamt = {{(SH_W-5){1'b0}}, shiftamt};
  end

  always_comb begin
    op_b  = selimregb ? imedext : regb;
    sum   = rega + op_b;
    diff  = rega - op_b;
    lt    = unsig ? (rega < op_b) : ($signed(rega) < $signed(op_b));
    alu_res = '0;
    case (aluop)
      3'b000:  alu_res = sum;
      3'b001:  alu_res = diff;
      3'b010:  alu_res = rega & op_b;
      3'b011:  alu_res = rega | op_b;
      3'b100:  alu_res = rega ^ op_b;
      3'b101:  alu_res = ~(rega | op_b);
      3'b110:  alu_res = {{(DATA_W-1){1'b0}}, lt};
      default: alu_res = op_b;
    endcase
    // Signed overflow: operands agree in sign (add) or differ (sub) and the result flips it.
    aluov = !unsig &&
            (((aluop == 3'b000) && (rega[MSB] == op_b[MSB]) && (sum[MSB]  != rega[MSB])) ||
             ((aluop == 3'b001) && (rega[MSB] != op_b[MSB]) && (diff[MSB] != rega[MSB])));
  end

  always_comb begin
    sh_res = regb;
    case (shiftop)
      2'b00:   sh_res = regb << shamt;
      2'b01:   sh_res = regb >> shamt;
      2'b10:   sh_res = $signed(regb) >>> shamt;
      default: sh_res = regb;
    endcase
    result = selalushift ? sh_res : alu_res;
  end
endmodule

module execute_x_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 4,
  parameter int FU_ID  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        is_x_functionalunit,
  input  logic              is_x_selalushift,
  input  logic              is_x_selimregb,
  input  logic [2:0]        is_x_aluop,
  input  logic              is_x_unsig,
  input  logic [1:0]        is_x_shiftop,
  input  logic [4:0]        is_x_shiftamt,
  input  logic [DATA_W-1:0] is_x_rega,
  input  logic [DATA_W-1:0] is_x_regb,
  input  logic [DATA_W-1:0] is_x_imedext,
  input  logic [REG_W-1:0]  is_x_regdest,
  input  logic              is_x_writereg,
  input  logic              is_x_writeov,
  input  logic              x_flush,
  input  logic              x_hold,
  input  logic [REG_W-1:0]  byp_addr,
  output logic              byp_hit,
  output logic [DATA_W-1:0] byp_value,
  output logic              x_busy,
  output logic [REG_W-1:0]  x_wb_regdest,
  output logic              x_wb_writereg,
  output logic [DATA_W-1:0] x_wb_wbvalue,
  output logic              x_wb_ovf
);
  logic [DATA_W-1:0] x0_result;
  logic              x0_aluov;

  execute_x_pipe_x0 #(.DATA_W(DATA_W)) u_x0 (
    .selalushift (is_x_selalushift),
    .selimregb   (is_x_selimregb),
    .aluop       (is_x_aluop),
    .unsig       (is_x_unsig),
    .shiftop     (is_x_shiftop),
    .shiftamt    (is_x_shiftamt),
    .rega        (is_x_rega),
    .regb        (is_x_regb),
    .imedext     (is_x_imedext),
    .result      (x0_result),
    .aluov       (x0_aluov)
  );

  logic                           p1_valid, p1_writereg, p1_ovf;
  logic [REG_W-1:0]               p1_regdest;
  logic [DATA_W-1:0]              p1_wbvalue;

  logic [DEPTH:1]                 valid_q, valid_d;
  logic [DEPTH:1]                 writereg_q, writereg_d;
  logic [DEPTH:1]                 ovf_q, ovf_d;
  logic [DEPTH:1][REG_W-1:0]      regdest_q, regdest_d;
  logic [DEPTH:1][DATA_W-1:0]     wbvalue_q, wbvalue_d;

  // Non-matching unit select enters as an all-zero bubble.
  always_comb begin
    p1_valid    = (is_x_functionalunit == 2'(FU_ID));
    p1_regdest  = p1_valid ? is_x_regdest : '0;
    p1_wbvalue  = p1_valid ? x0_result : '0;
    p1_writereg = p1_valid && is_x_writereg && (!x0_aluov || is_x_writeov) &&
                  (is_x_regdest != '0);
    p1_ovf      = p1_valid && x0_aluov && !is_x_writeov;
  end

  always_comb begin
    valid_d    = valid_q;
    writereg_d = writereg_q;
    ovf_d      = ovf_q;
    regdest_d  = regdest_q;
    wbvalue_d  = wbvalue_q;
    if (x_flush) begin
      valid_d    = '0;
      writereg_d = '0;
      ovf_d      = '0;
      regdest_d  = '0;
      wbvalue_d  = '0;
    end else if (!x_hold) begin
      valid_d[1]    = p1_valid;
      writereg_d[1] = p1_writereg;
      ovf_d[1]      = p1_ovf;
      regdest_d[1]  = p1_regdest;
      wbvalue_d[1]  = p1_wbvalue;
      for (int k = 2; k <= DEPTH; k++) begin
        valid_d[k]    = valid_q[k-1];
        writereg_d[k] = writereg_q[k-1];
        ovf_d[k]      = ovf_q[k-1];
        regdest_d[k]  = regdest_q[k-1];
        wbvalue_d[k]  = wbvalue_q[k-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q    <= '0;
      writereg_q <= '0;
      ovf_q      <= '0;
      regdest_q  <= '0;
      wbvalue_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      writereg_q <= writereg_d;
      ovf_q      <= ovf_d;
      regdest_q  <= regdest_d;
      wbvalue_q  <= wbvalue_d;
    end
  end

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    byp_hit   = 1'b0;
    byp_value = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (writereg_q[k] && (regdest_q[k] == byp_addr) && (byp_addr != '0)) begin
        byp_hit   = 1'b1;
        byp_value = wbvalue_q[k];
      end
    end
  end

  assign x_busy        = |valid_q;
  assign x_wb_regdest  = regdest_q[DEPTH];
  assign x_wb_writereg = writereg_q[DEPTH];
  assign x_wb_wbvalue  = wbvalue_q[DEPTH];
  assign x_wb_ovf      = ovf_q[DEPTH];
endmodule

// File: tb/tb_execute_x_pipe.sv
// Directed bench for execute_x_pipe: scoreboard entries carry an expected retire
// time in advancing cycles; every cycle the writeback, busy and bypass outputs are checked.

module tb_execute_x_pipe;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int DEPTH  = 4;
  localparam int FU_ID  = 1;

  logic              clock = 1'b0;
  logic              reset;
  logic [1:0]        is_x_functionalunit;
  logic              is_x_selalushift, is_x_selimregb, is_x_unsig;
  logic [2:0]        is_x_aluop;
  logic [1:0]        is_x_shiftop;
  logic [4:0]        is_x_shiftamt;
  logic [DATA_W-1:0] is_x_rega, is_x_regb, is_x_imedext;
  logic [REG_W-1:0]  is_x_regdest;
  logic              is_x_writereg, is_x_writeov;
  logic              x_flush, x_hold;
  logic [REG_W-1:0]  byp_addr;
  logic              byp_hit;
  logic [DATA_W-1:0] byp_value;
  logic              x_busy;
  logic [REG_W-1:0]  x_wb_regdest;
  logic              x_wb_writereg;
  logic [DATA_W-1:0] x_wb_wbvalue;
  logic              x_wb_ovf;

  execute_x_pipe #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .FU_ID(FU_ID)) dut (
    .clock(clock), .reset(reset),
    .is_x_functionalunit(is_x_functionalunit), .is_x_selalushift(is_x_selalushift),
    .is_x_selimregb(is_x_selimregb), .is_x_aluop(is_x_aluop), .is_x_unsig(is_x_unsig),
    .is_x_shiftop(is_x_shiftop), .is_x_shiftamt(is_x_shiftamt), .is_x_rega(is_x_rega),
    .is_x_regb(is_x_regb), .is_x_imedext(is_x_imedext), .is_x_regdest(is_x_regdest),
    .is_x_writereg(is_x_writereg), .is_x_writeov(is_x_writeov),
    .x_flush(x_flush), .x_hold(x_hold), .byp_addr(byp_addr),
    .byp_hit(byp_hit), .byp_value(byp_value), .x_busy(x_busy),
    .x_wb_regdest(x_wb_regdest), .x_wb_writereg(x_wb_writereg),
    .x_wb_wbvalue(x_wb_wbvalue), .x_wb_ovf(x_wb_ovf)
  );

  always #5 clock = ~clock;

  typedef struct {
    int                due;
    logic [REG_W-1:0]  dest;
    logic              wr;
    logic [DATA_W-1:0] val;
    logic              ovf;
  } exp_t;

  exp_t q[$];
  exp_t cur, pend, zero_e;
  bit   cur_v, pend_v;
  int   adv, n_cmp, n_bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    is_x_functionalunit = 2'd0;
    is_x_selalushift = 0; is_x_selimregb = 0; is_x_aluop = 0; is_x_unsig = 0;
    is_x_shiftop = 0; is_x_shiftamt = 0; is_x_rega = 0; is_x_regb = 0;
    is_x_imedext = 0; is_x_regdest = 0; is_x_writereg = 0; is_x_writeov = 0;
    x_flush = 0; x_hold = 0;
    pend_v = 0;
  endtask

  // One clock: update the scoreboard for what this edge does, then check outputs.
  task automatic tick();
    logic              eh;
    logic [DATA_W-1:0] ev;
    @(posedge clock);
    if (!reset || x_flush) begin
      q.delete();
      cur = zero_e; cur_v = 0;
    end else if (!x_hold) begin
      adv++;
      if (pend_v) begin
        pend.due = adv + DEPTH - 1;
        q.push_back(pend);
      end
      if (q.size() > 0 && q[0].due == adv) begin
        cur = q.pop_front(); cur_v = 1;
      end else begin
        cur = zero_e; cur_v = 0;
      end
    end
    #1;
    eh = 0; ev = '0;
    if (byp_addr != '0) begin
      if (cur_v && cur.wr && cur.dest == byp_addr) begin eh = 1; ev = cur.val; end
      foreach (q[i]) if (q[i].wr && q[i].dest == byp_addr) begin eh = 1; ev = q[i].val; end
    end
    chk("wb_regdest",  64'(x_wb_regdest),  64'(cur.dest));
    chk("wb_writereg", 64'(x_wb_writereg), 64'(cur.wr));
    chk("wb_wbvalue",  64'(x_wb_wbvalue),  64'(cur.val));
    chk("wb_ovf",      64'(x_wb_ovf),      64'(cur.ovf));
    chk("busy",        64'(x_busy),        64'(cur_v || q.size() > 0));
    chk("byp_hit",     64'(byp_hit),       64'(eh));
    chk("byp_value",   64'(byp_value),     64'(ev));
  endtask

  task automatic issue(input logic [2:0] op, input logic selimm, input logic selsh,
                       input logic uns, input logic [1:0] shop, input logic [4:0] amt,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [4:0] dest, input logic wr, input logic wov,
                       input logic [31:0] e_val, input logic e_wr, input logic e_ovf);
    is_x_functionalunit = 2'(FU_ID);
    is_x_aluop = op; is_x_selimregb = selimm; is_x_selalushift = selsh; is_x_unsig = uns;
    is_x_shiftop = shop; is_x_shiftamt = amt;
    is_x_rega = a; is_x_regb = b; is_x_imedext = imm;
    is_x_regdest = dest; is_x_writereg = wr; is_x_writeov = wov;
    pend.due = 0; pend.dest = dest; pend.wr = e_wr; pend.val = e_val; pend.ovf = e_ovf;
    pend_v = 1;
    tick();
    idle();
  endtask

  // Junk instruction offered while held/flushed; it must never enter the pipe.
  task automatic junk();
    is_x_functionalunit = 2'(FU_ID);
    is_x_aluop = 3'b000; is_x_rega = 32'h111; is_x_regb = 32'h222;
    is_x_regdest = 5'd9; is_x_writereg = 1;
  endtask

  initial begin
    zero_e = '{due: 0, dest: '0, wr: 1'b0, val: '0, ovf: 1'b0};
    cur = zero_e; pend = zero_e; cur_v = 0; pend_v = 0;
    adv = 0; n_cmp = 0; n_bad = 0;

    // Reset with random inputs, then idle.
    reset = 0;
    is_x_functionalunit = 2'($urandom); is_x_selalushift = 1'($urandom);
    is_x_selimregb = 1'($urandom); is_x_aluop = 3'($urandom); is_x_unsig = 1'($urandom);
    is_x_shiftop = 2'($urandom); is_x_shiftamt = 5'($urandom);
    is_x_rega = $urandom; is_x_regb = $urandom; is_x_imedext = $urandom;
    is_x_regdest = 5'($urandom); is_x_writereg = 1'($urandom); is_x_writeov = 1'($urandom);
    x_flush = 1'($urandom); x_hold = 1'($urandom); byp_addr = 5'd0;
    tick(); tick();
    reset = 1;
    idle();
    repeat (10) tick();

    // Latency.
    byp_addr = 5'd3;
    issue(3'b000, 0, 0, 0, 2'b00, 5'd0, 32'd5, 32'd7, 32'd0, 5'd3, 1, 0, 32'd12, 1, 0);
    repeat (DEPTH + 1) tick();

    // Overflow variants.
    issue(3'b000, 0, 0, 0, 2'b00, 5'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 5'd6, 1, 0, 32'h80000000, 0, 1);
    issue(3'b000, 0, 0, 0, 2'b00, 5'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 5'd6, 1, 1, 32'h80000000, 1, 0);
    issue(3'b000, 0, 0, 1, 2'b00, 5'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 5'd6, 1, 0, 32'h80000000, 1, 0);
    issue(3'b001, 0, 0, 0, 2'b00, 5'd0, 32'h80000000, 32'd1, 32'd0, 5'd4, 1, 0, 32'h7FFFFFFF, 0, 1);
    repeat (DEPTH + 1) tick();

    // Shifter.
    byp_addr = 5'd7;
    issue(3'b000, 0, 1, 0, 2'b10, 5'd4, 32'd0, 32'h80000000, 32'd0, 5'd7, 1, 0, 32'hF8000000, 1, 0);
    issue(3'b000, 0, 1, 0, 2'b01, 5'd4, 32'd0, 32'h80000000, 32'd0, 5'd7, 1, 0, 32'h08000000, 1, 0);
    issue(3'b000, 0, 1, 0, 2'b00, 5'd4, 32'd0, 32'h80000000, 32'd0, 5'd7, 1, 0, 32'h00000000, 1, 0);
    issue(3'b000, 0, 1, 0, 2'b00, 5'd4, 32'd0, 32'h00000001, 32'd0, 5'd8, 1, 0, 32'h00000010, 1, 0);
    issue(3'b000, 0, 1, 0, 2'b10, 5'd0, 32'd0, 32'h80000001, 32'd0, 5'd8, 1, 0, 32'h80000001, 1, 0);
    issue(3'b000, 0, 1, 0, 2'b11, 5'd9, 32'd0, 32'h12345678, 32'd0, 5'd8, 1, 0, 32'h12345678, 1, 0);
    repeat (DEPTH + 1) tick();

    // Remaining ALU ops.
    issue(3'b010, 0, 0, 0, 2'b00, 5'd0, 32'h0000F0F0, 32'h0000FF00, 32'd0, 5'd10, 1, 0, 32'h0000F000, 1, 0);
    issue(3'b011, 0, 0, 0, 2'b00, 5'd0, 32'h0000F0F0, 32'h0000FF00, 32'd0, 5'd11, 1, 0, 32'h0000FFF0, 1, 0);
    issue(3'b100, 0, 0, 0, 2'b00, 5'd0, 32'h0000F0F0, 32'h0000FF00, 32'd0, 5'd12, 1, 0, 32'h00000FF0, 1, 0);
    issue(3'b101, 0, 0, 0, 2'b00, 5'd0, 32'h0000F0F0, 32'h0000FF00, 32'd0, 5'd13, 1, 0, 32'hFFFF000F, 1, 0);
    issue(3'b110, 0, 0, 0, 2'b00, 5'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd14, 1, 0, 32'd1, 1, 0);
    issue(3'b110, 0, 0, 1, 2'b00, 5'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd14, 1, 0, 32'd0, 1, 0);
    issue(3'b111, 1, 0, 0, 2'b00, 5'd0, 32'h5, 32'h9, 32'h1234, 5'd15, 1, 0, 32'h1234, 1, 0);
    issue(3'b000, 0, 0, 0, 2'b00, 5'd0, 32'd1, 32'd2, 32'd0, 5'd0, 1, 0, 32'd3, 0, 0);
    issue(3'b000, 0, 0, 0, 2'b00, 5'd0, 32'd1, 32'd2, 32'd0, 5'd16, 0, 0, 32'd3, 0, 0);
    repeat (DEPTH + 1) tick();

    // Hold: A, B back-to-back, then freeze for 3 cycles.
    byp_addr = 5'd2;
    issue(3'b000, 0, 0, 0, 2'b00, 5'd0, 32'd100, 32'd1, 32'd0, 5'd1, 1, 0, 32'd101, 1, 0);
    issue(3'b000, 0, 0, 0, 2'b00, 5'd0, 32'd200, 32'd2, 32'd0, 5'd2, 1, 0, 32'd202, 1, 0);
    junk(); x_hold = 1;
    repeat (3) tick();
    idle();
    repeat (DEPTH + 2) tick();

    // Flush together with hold on the cycle after B.
    issue(3'b000, 0, 0, 0, 2'b00, 5'd0, 32'd100, 32'd1, 32'd0, 5'd1, 1, 0, 32'd101, 1, 0);
    issue(3'b000, 0, 0, 0, 2'b00, 5'd0, 32'd200, 32'd2, 32'd0, 5'd2, 1, 0, 32'd202, 1, 0);
    junk(); x_flush = 1; x_hold = 1;
    tick();
    idle();
    repeat (DEPTH + 2) tick();

    // Bypass: two writes to r5, youngest value wins while both in flight.
    byp_addr = 5'd5;
    issue(3'b000, 1, 0, 0, 2'b00, 5'd0, 32'd3, 32'd0, 32'd7, 5'd5, 1, 0, 32'd10, 1, 0);
    issue(3'b000, 1, 0, 0, 2'b00, 5'd0, 32'd15, 32'd0, 32'd5, 5'd5, 1, 0, 32'd20, 1, 0);
    repeat (DEPTH + 1) tick();
    byp_addr = 5'd0;
    issue(3'b000, 1, 0, 0, 2'b00, 5'd0, 32'd1, 32'd0, 32'd1, 5'd0, 1, 0, 32'd2, 0, 0);
    repeat (DEPTH + 1) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/execute_x_pipe.md
Name: execute_x_pipe

Overview:
- Parametrised successor to the fixed four-stage integer X pipe.
- ALU/shifter evaluation in X0, then DEPTH-1 pass-through stages, then the result is presented to writeback.
- Adds over the fixed pipe:
  - configurable data width, depth and functional-unit ID;
  - global hold and flush;
  - overflow-exception flag;
  - combinational bypass lookup across all in-flight stages.
- Sits between issue and writeback, alongside the other functional units.

Parameters:
DATA_W, 32, datapath width (rega/regb/imedext/results)
REG_W, 5, register-index width
DEPTH, 4, number of pipeline registers from issue to x_wb outputs; legal 2..8
FU_ID, 1, is_x_functionalunit value that selects this unit

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
is_x_functionalunit  in  2  unit select; instruction valid when == FU_ID
is_x_selalushift  in  1  1=shifter result, 0=ALU result
is_x_selimregb  in  1  ALU B operand: 1=imedext, 0=regb
is_x_aluop  in  3  ALU operation
is_x_unsig  in  1  1=unsigned (no overflow detection)
is_x_shiftop  in  2  shift operation
is_x_shiftamt  in  5  shift amount (only log2(DATA_W) LSBs used)
is_x_rega  in  DATA_W  operand A
is_x_regb  in  DATA_W  operand B / shifter input
is_x_imedext  in  DATA_W  extended immediate
is_x_regdest  in  REG_W  destination register
is_x_writereg  in  1  instruction writes a register
is_x_writeov  in  1  1=write result even on overflow
x_flush  in  1  kill all in-flight instructions
x_hold  in  1  freeze the whole pipe
byp_addr  in  REG_W  bypass query register
byp_hit  out  1  in-flight write to byp_addr exists
byp_value  out  DATA_W  value of the youngest matching in-flight write
x_busy  out  1  any stage holds a valid instruction
x_wb_regdest  out  REG_W  writeback destination
x_wb_writereg  out  1  writeback enable
x_wb_wbvalue  out  DATA_W  writeback value
x_wb_ovf  out  1  overflow exception for the retiring instruction

Behaviour:
- Reset: on a rising edge with reset=0, every stage clears valid, regdest, writereg, wbvalue and ovf to 0. All outputs read 0 in the following cycle.
- Pipeline registers:
  - P1..PDEPTH, each holding {valid, regdest, writereg, wbvalue, ovf}.
  - PDEPTH drives x_wb_*.
  - Latency: an instruction sampled at edge N appears on x_wb_* after edge N+DEPTH-1, for one cycle.
- X0 ALU (B = selimregb ? imedext : regb):
  - aluop: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor, 110 slt (signed; unsigned if unsig), 111 pass B.
  - Results are DATA_W bits, wrap-around.
  - aluov = 1 only for add/sub with unsig=0 and two's-complement signed overflow.
- X0 shifter on regb:
  - shiftop: 00 sll, 01 srl, 10 sra, 11 pass.
  - A shift amount of 0 leaves the value unchanged.
- P1 capture:
  - valid = (functionalunit==FU_ID).
  - If valid:
    - regdest = is_x_regdest;
    - wbvalue = selalushift ? shifter : ALU;
    - writereg = is_x_writereg & (!aluov | writeov) & (regdest!=0);
    - ovf = aluov & !writeov.
  - If not valid: all P1 fields are 0 (bubble).
- Advance: each edge, Pk+1 <= Pk when x_hold=0.
- Hold (x_hold=1, reset=1, x_flush=0):
  - All registers keep their value and the issue inputs are ignored.
  - The issuer keeps its instruction.
  - The x_wb_* outputs keep presenting the same instruction.
- Flush (x_flush=1):
  - At the edge, all Pk clear to 0, including the instruction currently on the issue inputs.
  - Priority: reset > flush > hold > advance.
- Bypass (combinational):
  - byp_hit = OR over k of (Pk.writereg & Pk.regdest==byp_addr) with byp_addr != 0.
  - byp_value = wbvalue of the smallest matching k (youngest); 0 when there is no hit.
- x_busy = OR of all Pk.valid.
- x_wb_ovf is asserted even though x_wb_writereg is suppressed.

Test Plan:
- Reset then idle: reset=0 for 2 edges with random inputs → all outputs 0, x_busy=0; then 10 idle cycles with functionalunit=0 → outputs stay 0.
- Latency, DEPTH=4: add, rega=5, regb=7, regdest=3, writereg=1, sampled at edge 0 → x_wb_regdest=3, writereg=1, wbvalue=12 after edge 3, for one cycle only.
- Overflow, signed add 0x7FFFFFFF+1 with unsig=0:
  - writeov=0 → x_wb_writereg=0, x_wb_ovf=1, wbvalue=0x80000000;
  - writeov=1 → writereg=1, ovf=0;
  - unsig=1 → ovf=0, writereg=1.
- Shifter, selalushift=1, regb=0x80000000, shiftamt=4:
  - sra → 0xF8000000;
  - srl → 0x08000000;
  - sll → 0x00000000.
- Hold/flush:
  - Issue A (dest 1), B (dest 2) back-to-back; x_hold=1 for 3 cycles → x_wb sequence is unchanged, only delayed 3 cycles.
  - Repeat with x_flush=1 and x_hold=1 together on the cycle after B → both killed, x_busy=0 next cycle, no writeback.
- Bypass: issue r5=10, then r5=20 (addi via imedext), with byp_addr=5:
  - → hit=1, value=20 while both are in flight;
  - after the younger retires → hit=0;
  - byp_addr=0 with regdest=0 in flight → hit=0.
